// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: M-stage <-> CP0 bundle; master drives mfc0/mtc0, victim and interrupt inputs, slave returns int_req/epc/dout/answer_interrupt
interface cp0_ctrl_if #(parameter int NUM_HWINT = 6);
    logic [4:0]           addr;
    logic [31:0]          din;
    logic                 we;
    logic [31:0]          pc;
    logic                 bd;
    logic [4:0]           exc_code;
    logic [NUM_HWINT-1:0] hw_int;
    logic                 eret;
    logic                 int_req;
    logic [31:0]          epc;
    logic [31:0]          dout;
    logic                 answer_interrupt;
    modport master (output addr, din, we, pc, bd, exc_code, hw_int, eret,
                    input int_req, epc, dout, answer_interrupt);
    modport slave (input addr, din, we, pc, bd, exc_code, hw_int, eret,
                   output int_req, epc, dout, answer_interrupt);
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS CP0 (SR/Cause/EPC/PRId) with interrupt/exception arbitration; optional Count/Compare timer under CP0_CTRL_TIMER_EN
// Ports: clk, reset (async, active-high), bus (cp0_ctrl_if.slave: mfc0/mtc0 access, victim pc/bd/exc_code, hw_int, eret -> int_req, epc, dout, answer_interrupt)
module cp0_ctrl #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID      = 32'h0000_0000
) (
    input logic      clk,
    input logic      reset,
    cp0_ctrl_if.slave bus
);
    logic [5:0]  im_q, im_d, ip_q, hw;
    logic        ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d, count_q, compare_q, sr, cause;
    logic        ti_q, irq, exc, req, wr, wsr, wepc;
    always_comb begin
        hw = '0;
        hw[NUM_HWINT-1:0] = bus.hw_int;
    end
    // TI shares the IM[15] mask with hardware line 5
    assign irq  = (|((ip_q | {ti_q, 5'b0}) & im_q)) & ie_q & ~exl_q;
    assign exc  = (bus.exc_code != 5'd0) & ~exl_q;
    assign req  = irq | exc;
    assign wr   = bus.we & ~req;
    assign wsr  = wr && bus.addr == 5'd12;
    assign wepc = wr && bus.addr == 5'd14;
    assign sr    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause = {bd_q, ti_q, 14'b0, ip_q, 3'b0, code_q, 2'b0};
    always_comb begin
        im_d   = wsr ? bus.din[15:10] : im_q;
        ie_d   = wsr ? bus.din[0] : ie_q;
        exl_d  = req ? 1'b1 : bus.eret ? 1'b0 : wsr ? bus.din[1] : exl_q;
        code_d = req ? (irq ? 5'd0 : bus.exc_code) : code_q;
        bd_d   = req ? bus.bd : bd_q;
        epc_d  = req ? ((bus.bd ? bus.pc - 32'd4 : bus.pc) & ~32'd3) :
                 wepc ? {bus.din[31:2], 2'b0} : epc_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q   <= '0;
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            bd_q   <= 1'b0;
            code_q <= '0;
            ip_q   <= '0;
            epc_q  <= '0;
        end else begin
            im_q   <= im_d;
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            ip_q   <= hw;
            epc_q  <= epc_d;
        end
    end
`ifdef CP0_CTRL_TIMER_EN
    logic [31:0] count_d, compare_d;
    logic        ti_d;
    // TI compares against Count's next value so it rises on the edge Count lands on Compare
    always_comb begin
        count_d   = (wr && bus.addr == 5'd9) ? bus.din : count_q + 32'd1;
        compare_d = (wr && bus.addr == 5'd11) ? bus.din : compare_q;
        ti_d      = (wr && bus.addr == 5'd11) ? 1'b0 :
                    ti_q | (count_d == compare_q && compare_q != 32'd0);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end
`else
    assign count_q   = '0;
    assign compare_q = '0;
    assign ti_q      = 1'b0;
`endif
    assign bus.int_req          = req;
    assign bus.answer_interrupt = irq;
    assign bus.epc              = epc_q;
    assign bus.dout = (bus.addr == 5'd9)  ? count_q   :
                      (bus.addr == 5'd11) ? compare_q :
                      (bus.addr == 5'd12) ? sr        :
                      (bus.addr == 5'd13) ? cause     :
                      (bus.addr == 5'd14) ? epc_q     :
                      (bus.addr == 5'd15) ? PRID      : 32'd0;
endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed test-plan scenarios plus randomized traffic checked against a register-level CP0 model
module tb_cp0_ctrl;
    localparam int          NH   = 6;
    localparam logic [31:0] PRID = 32'h0001_8C01;
`ifdef CP0_CTRL_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    cp0_ctrl_if #(.NUM_HWINT(NH)) bus();
    cp0_ctrl #(.NUM_HWINT(NH), .PRID(PRID)) dut (.clk(clk), .reset(reset), .bus(bus));
    int total = 0;
    int bad = 0;
    logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic m_reset();
        m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0;
    endtask
    function automatic logic m_irq();
        logic [31:0] pend;
        pend = ((m_cause >> 10) & 32'h3F) | (m_cause[30] ? 32'h20 : 32'h0);
        return ((pend & (m_sr >> 10)) != 0) && m_sr[0] && !m_sr[1];
    endfunction
    function automatic logic m_exc();
        return bus.exc_code != 0 && !m_sr[1];
    endfunction
    function automatic logic [31:0] m_dout();
        case (bus.addr)
            9:  return TMR ? m_count : 0;
            11: return TMR ? m_compare : 0;
            12: return m_sr;
            13: return m_cause;
            14: return m_epc;
            15: return PRID;
            default: return 0;
        endcase
    endfunction
    task automatic drive(input logic [4:0] a, input logic [31:0] d, input logic w,
                         input logic [31:0] p, input logic b, input logic [4:0] e,
                         input logic [NH-1:0] h, input logic r);
        bus.addr = a; bus.din = d; bus.we = w; bus.pc = p;
        bus.bd = b; bus.exc_code = e; bus.hw_int = h; bus.eret = r;
        @(negedge clk);
        chk("int_req", bus.int_req, m_irq() | m_exc());
        chk("answer_interrupt", bus.answer_interrupt, m_irq());
        chk("epc", bus.epc, m_epc);
        chk("dout", bus.dout, m_dout());
    endtask
    task automatic tick();
        logic [31:0] sr, cause, epc, cnt, cmp, nxt;
        logic irq, req, wr;
        @(posedge clk);
        irq = m_irq();
        req = irq | m_exc();
        wr = bus.we && !req;
        sr = m_sr; cause = m_cause; epc = m_epc; cnt = m_count; cmp = m_compare;
        if (req) begin
            sr = sr | 32'h2;
            cause[6:2] = irq ? 5'd0 : bus.exc_code;
            cause[31] = bus.bd;
            epc = (bus.bd ? bus.pc - 32'd4 : bus.pc) & ~32'd3;
        end else if (wr) begin
            if (bus.addr == 12) sr = bus.din & 32'h0000_FC03;
            if (bus.addr == 14) epc = bus.din & ~32'd3;
        end
        if (bus.eret && !req) sr[1] = 1'b0;
        cause[15:10] = 6'(bus.hw_int);
        if (TMR) begin
            nxt = (wr && bus.addr == 9) ? bus.din : cnt + 1;
            if (wr && bus.addr == 11) begin
                cmp = bus.din;
                cause[30] = 1'b0;
            end else if (nxt == m_compare && m_compare != 0) cause[30] = 1'b1;
            cnt = nxt;
        end
        m_sr = sr; m_cause = cause; m_epc = epc; m_count = cnt; m_compare = cmp;
        #1;
    endtask
    task automatic step(input logic [4:0] a, input logic [31:0] d, input logic w,
                        input logic [31:0] p, input logic b, input logic [4:0] e,
                        input logic [NH-1:0] h, input logic r);
        drive(a, d, w, p, b, e, h, r);
        tick();
    endtask
    initial begin
        bit hit;
        logic [4:0] a;
        logic [31:0] d;
        m_reset();
        drive(15, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_dout_prid", bus.dout, PRID);
        chk("rst_int_req", bus.int_req, 0);
        #2 reset = 1'b0;
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // exception capture
        drive(0, 0, 0, 32'h3010, 0, 12, 0, 0);
        chk("ov_req", bus.int_req, 1);
        chk("ov_ans", bus.answer_interrupt, 0);
        tick();
        drive(13, 0, 0, 32'h3010, 0, 12, 0, 0);
        chk("ov_code", bus.dout[6:2], 12);
        chk("ov_epc", bus.epc, 32'h3010);
        chk("ov_repeat_blocked", bus.int_req, 0);
        tick();
        drive(12, 0, 0, 0, 0, 0, 0, 0);
        chk("ov_exl", bus.dout[1], 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        // delay-slot capture
        step(13, 0, 0, 32'h3020, 1, 10, 0, 0);
        drive(13, 0, 0, 0, 0, 0, 0, 0);
        chk("bd_epc", bus.epc, 32'h301C);
        chk("bd_bit", bus.dout[31], 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        // interrupt beats simultaneous exception
        step(12, 32'h0000_0401, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        drive(13, 0, 0, 32'h5000, 0, 4, 0, 0);
        chk("irq_req", bus.int_req, 1);
        chk("irq_ans", bus.answer_interrupt, 1);
        tick();
        drive(13, 0, 0, 0, 0, 0, 0, 0);
        chk("irq_code", bus.dout[6:2], 0);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        // mtc0 dropped under exception, then eret with held interrupt
        drive(14, 32'h4000, 1, 32'h3030, 0, 5, 0, 0);
        chk("drop_req", bus.int_req, 1);
        tick();
        drive(14, 0, 0, 0, 0, 0, 0, 0);
        chk("drop_epc", bus.dout, 32'h3030);
        tick();
        step(0, 0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 32'h6000, 0, 0, 1, 0);
        chk("eret_irq_next", bus.int_req, 1);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef CP0_CTRL_TIMER_EN
        step(12, 32'h0000_8001, 1, 0, 0, 0, 0, 0);
        step(9, 0, 1, 0, 0, 0, 0, 0);
        step(11, 20, 1, 0, 0, 0, 0, 0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            drive(13, 0, 0, 0, 0, 0, 0, 0);
            if (bus.int_req) hit = 1'b1;
            else tick();
        end
        chk("ti_req", bus.int_req, 1);
        chk("ti_bit", bus.dout[30], 1);
        chk("ti_ans", bus.answer_interrupt, 1);
        tick();
        step(11, 0, 1, 0, 0, 0, 0, 0);
        drive(13, 0, 0, 0, 0, 0, 0, 0);
        chk("ti_clear", bus.dout[30], 0);
        tick();
        step(0, 0, 0, 0, 0, 0, 0, 1);
`else
        step(9, 32'h1234, 1, 0, 0, 0, 0, 0);
        drive(9, 0, 0, 0, 0, 0, 0, 0);
        chk("count_absent", bus.dout, 0);
        tick();
`endif
        // async reset while handling an exception
        step(0, 0, 0, 32'h3040, 0, 8, 0, 0);
        drive(14, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_epc", bus.epc, 32'h3040);
        #2 reset = 1'b1;
        #1;
        m_reset();
        chk("arst_int_req", bus.int_req, 0);
        chk("arst_ans", bus.answer_interrupt, 0);
        chk("arst_epc", bus.epc, 0);
        chk("arst_dout", bus.dout, 0);
        bus.addr = 15;
        #1 chk("arst_prid", bus.dout, PRID);
        reset = 1'b0;
        tick();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 6))
                0: a = 9;
                1: a = 11;
                2: a = 12;
                3: a = 13;
                4: a = 14;
                5: a = 15;
                default: a = 5'($urandom);
            endcase
            d = $urandom;
            if (a == 9 || a == 11) d = $urandom_range(0, 63);
            if (a == 12 && $urandom_range(0, 1) == 1) d = d | 32'h1;
            step(a, d, $urandom_range(0, 2) == 0, $urandom, 1'($urandom),
                 ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                 ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0,
                 $urandom_range(0, 3) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised coprocessor-0 successor for the five-stage MIPS pipeline, instantiated at the M stage. It holds SR, Cause, EPC and PRId, and arbitrates hardware interrupts against synchronous exceptions. It raises a single flush/redirect request (`int_req`) and supports `eret`. New relative to the current CP0: a configurable interrupt-line count, a PRId parameter and an optional Count/Compare timer that posts an internal interrupt.

## Interface
- `NUM_HWINT`, 6: external interrupt lines, 1..6; map to IP/IM bits 10..(9+NUM_HWINT).
- `PRID`, 32'h0000_0000: value returned from register 15.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `addr` in 5: CP0 register number for mfc0/mtc0.
- `din` in 32: mtc0 write data, already forwarded.
- `we` in 1: mtc0 write enable.
- `pc` in 32: PC of the M-stage victim instruction.
- `bd` in 1: the victim is in a branch delay slot.
- `exc_code` in 5: pending synchronous exception code; 0 means none.
- `hw_int` in NUM_HWINT: level-sensitive interrupt lines.
- `eret` in 1: eret in M stage.
- `int_req` out 1: take exception/interrupt this cycle; flush the pipeline and redirect to 0x4180.
- `epc` out 32: current EPC register.
- `dout` out 32: mfc0 read data.
- `answer_interrupt` out 1: `int_req` is caused by an interrupt, not an exception.

## Operation
- **SR (12)**
  - Writable fields: IM[15:10], EXL[1], IE[0].
  - All other bits read 0.
- **Cause (13)**
  - BD[31], TI[30], IP[15:10] and ExcCode[6:2] are read-only to software.
  - IP[10+i] is registered from `hw_int[i]` every cycle.
  - Unused IP bits are 0.
- **EPC (14)**
  - Writable; bits [1:0] are forced to 0 on write.
- **PRId (15)**
  - Constant `PRID`.
- **Unimplemented reads**
  - Any other `addr` reads 0.
- **Interrupt pending**
  - `irq = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL`.
- **Exception pending**
  - `exc = (exc_code != 0) & ~SR.EXL`.
- **Request and priority**
  - `int_req = irq | exc`; `answer_interrupt = irq`.
  - An interrupt has priority over a simultaneous exception.
- **On a clock edge with `int_req`**
  - EXL <= 1.
  - Cause.ExcCode <= 0 if `irq`, else `exc_code`.
  - Cause.BD <= `bd`.
  - EPC <= (`bd` ? `pc`-4 : `pc`) & ~3.
- **mtc0 writes**
  - Committed only when `we & ~int_req`; the exception wins and the write is dropped.
- **eret**
  - EXL <= 0 at the edge.
  - `int_req` is 0 while EXL=1, so an interrupt pending at eret is taken in the following cycle.
- **IP versus the other updates**
  - The IP update is independent of all of the above and happens every cycle.

## Timing
- **Combinational outputs**
  - `int_req`, `answer_interrupt` and `dout` are combinational on the current register state and inputs.
  - `dout` returns the pre-write value when the same register is written that cycle.
- **Interrupt latency**
  - `hw_int` rise to `int_req` takes 1 cycle, because IP is registered.
- **Register updates**
  - All register updates occur on the rising edge of `clk`.
- **Reset**
  - Async `reset` forces SR=0, Cause=0, EPC=0, Count=0 and Compare=0 immediately.
  - Outputs are then `int_req`=0, `answer_interrupt`=0, `epc`=0, `dout`=`PRID` if addr=15 else 0.
- **Reset mid-handling**
  - Reset while EXL=1 clears EXL; no pending state survives.

## Configuration
- Macro: `CP0_CTRL_TIMER_EN`.
- **Defined**
  - Count (9) increments by 1 every cycle and wraps at 2^32.
  - Count and Compare (11) are writable via mtc0.
  - When Count's next value equals Compare and Compare != 0, Cause.TI <= 1.
  - TI stays set until Compare is written.
  - TI is ORed into the IP bit 15 term of `irq`, masked by IM[15].
  - A write to Count takes priority over that cycle's increment.
- **Undefined**
  - Count, Compare and TI are absent and read 0; writes to 9 and 11 are ignored.

## Test plan
- **Exception capture:** reset, `exc_code`=12 (Ov), `pc`=0x3010, `bd`=0 → `int_req`=1, `answer_interrupt`=0. After the edge: EPC=0x3010, Cause[6:2]=12, SR.EXL=1, and `int_req`=0 on a repeat exception.
- **Delay-slot capture:** `exc_code`=10, `pc`=0x3020, `bd`=1 → EPC=0x301C, Cause[31]=1.
- **Interrupt over exception:** mtc0 SR=0x0000_0401, `hw_int[0]`=1 for 1 cycle, then `int_req`=1 with `exc_code`=4 simultaneously → ExcCode=0, `answer_interrupt`=1.
- **mtc0 dropped on exception:** mtc0 EPC=0x4000 in the same cycle as `exc_code`=5, `pc`=0x3030 → EPC=0x3030. Then eret → EXL=0, and a held `hw_int` produces `int_req` the next cycle.
- **Timer (with `CP0_CTRL_TIMER_EN`):** SR=0x0000_8001, Compare=20 → TI=1 and `int_req`=1 once Count reaches 20. Writing Compare clears TI. Without the macro, reads of reg 9 return 0.
- **Async reset:** assert `reset` mid-cycle with EXL=1 and EPC=0x3040 → all outputs 0 before the next edge.
